// File: rtl/timer_cmp_pkg.sv
// Shared types, default sizes and the round-robin search function for the
// timer compare scheduler.
package timer_cmp_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 64;
    localparam int MAX_CH     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // First armed index strictly after ptr, wrapping; ptr itself is checked last
    // so a lone armed channel is revisited. Returns ptr when nothing is armed.
    function automatic int next_armed(input logic [MAX_CH-1:0] armed,
                                      input int ptr,
                                      input int num_ch);
        int idx;
        logic [MAX_CH-1:0] sh;
        next_armed = ptr;
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= num_ch) begin
                idx = (ptr + k) % num_ch;
                sh  = armed >> idx;
                if (sh[0]) next_armed = idx;
            end
        end
    endfunction

endpackage

// File: rtl/timer_cmp_sched_if.sv
// Configuration and status bus of the timer compare scheduler.
// TIMER_CMP_AUTO_RELOAD_EN adds the period and reload fields.
interface timer_cmp_sched_if
    import timer_cmp_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_cmp;
    logic              cfg_arm;
`ifdef TIMER_CMP_AUTO_RELOAD_EN
    logic [CNT_W-1:0]  cfg_per;
    logic              cfg_reload;
`endif
    logic [NUM_CH-1:0] int_en;
    logic [NUM_CH-1:0] int_clr;
    logic [NUM_CH-1:0] int_sts;
    logic [NUM_CH-1:0] cmp_match;
    logic [NUM_CH-1:0] armed;
    logic              tim_int;

`ifdef TIMER_CMP_AUTO_RELOAD_EN
    modport master (output cfg_wr, cfg_ch, cfg_cmp, cfg_arm, cfg_per, cfg_reload,
                           int_en, int_clr,
                    input  int_sts, cmp_match, armed, tim_int);
    modport slave  (input  cfg_wr, cfg_ch, cfg_cmp, cfg_arm, cfg_per, cfg_reload,
                           int_en, int_clr,
                    output int_sts, cmp_match, armed, tim_int);
`else
    modport master (output cfg_wr, cfg_ch, cfg_cmp, cfg_arm, int_en, int_clr,
                    input  int_sts, cmp_match, armed, tim_int);
    modport slave  (input  cfg_wr, cfg_ch, cfg_cmp, cfg_arm, int_en, int_clr,
                    output int_sts, cmp_match, armed, tim_int);
`endif

endinterface

// File: rtl/timer_cmp_rr_pick.sv
// Round-robin picker: next armed channel after ptr, priority rotated from ptr+1.
module timer_cmp_rr_pick
    import timer_cmp_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] armed,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   pick
);
    logic [MAX_CH-1:0] armed_ext;

    always_comb begin
        armed_ext             = '0;
        armed_ext[NUM_CH-1:0] = armed;
        pick                  = CH_W'(next_armed(armed_ext, int'(ptr), NUM_CH));
    end

endmodule

// File: rtl/timer_cmp_sched.sv
// Shares one magnitude comparator across NUM_CH timer compare channels.
// TIMER_CMP_AUTO_RELOAD_EN enables periodic (auto-reload) channels.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | no scanning; waits for timer_en, !dbg_mode and an armed channel
//  ST_SCAN | one armed channel compared against cnt per cycle (held in dbg)
module timer_cmp_sched
    import timer_cmp_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer_en,
    input  logic             dbg_mode,
    input  logic [CNT_W-1:0] cnt,
    timer_cmp_sched_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cmp_r [NUM_CH];
    logic [NUM_CH-1:0] armed_r, sts_r, match_r;
    logic [NUM_CH-1:0] hit_vec, disarm_vec;
    logic [CH_W-1:0]   ptr, ptr_nxt;
    logic              scan_step, hit, write_hit;

`ifdef TIMER_CMP_AUTO_RELOAD_EN
    logic [CNT_W-1:0]  per_r [NUM_CH];
    logic [NUM_CH-1:0] reload_r, wrap_r;
    logic [CNT_W-1:0]  cnt_prev;
    logic [CNT_W:0]    reload_sum;
    logic              cnt_wrapped;

    assign reload_sum  = {1'b0, cmp_r[ptr]} + {1'b0, per_r[ptr]};
    assign cnt_wrapped = cnt < cnt_prev;
    assign disarm_vec  = hit_vec & ~reload_r;
    // A compare value that wrapped past 2^CNT_W waits until cnt wraps too.
    assign hit         = scan_step && armed_r[ptr] && !wrap_r[ptr] && (cnt >= cmp_r[ptr]);
`else
    assign disarm_vec  = hit_vec;
    assign hit         = scan_step && armed_r[ptr] && (cnt >= cmp_r[ptr]);
`endif

    assign write_hit = bus.cfg_wr && (bus.cfg_ch == ptr);
    assign hit_vec   = (hit && !write_hit) ? (NUM_CH'(1) << ptr) : '0;

    timer_cmp_rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
        .armed (armed_r),
        .ptr   (ptr),
        .pick  (ptr_nxt)
    );

    always_comb begin
        state_nxt = state;
        scan_step = 1'b0;
        case (state)
            ST_IDLE: if (timer_en && !dbg_mode && (armed_r != '0)) state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (!timer_en || (armed_r == '0)) state_nxt = ST_IDLE;
                else if (!dbg_mode)               scan_step = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            armed_r <= '0;
            sts_r   <= '0;
            match_r <= '0;
            for (int i = 0; i < NUM_CH; i++) cmp_r[i] <= '0;
`ifdef TIMER_CMP_AUTO_RELOAD_EN
            for (int i = 0; i < NUM_CH; i++) per_r[i] <= '0;
            reload_r <= '0;
            wrap_r   <= '0;
            cnt_prev <= '0;
`endif
        end else begin
            state   <= state_nxt;
            match_r <= hit_vec;
            sts_r   <= (sts_r & ~bus.int_clr) | hit_vec;
            armed_r <= armed_r & ~disarm_vec;
            if (scan_step) ptr <= ptr_nxt;
`ifdef TIMER_CMP_AUTO_RELOAD_EN
            cnt_prev <= cnt;
            if (cnt_wrapped) wrap_r <= '0;
            if ((hit_vec != '0) && reload_r[ptr]) begin
                cmp_r[ptr] <= reload_sum[CNT_W-1:0];
                if (reload_sum[CNT_W] && !cnt_wrapped) wrap_r[ptr] <= 1'b1;
            end
`endif
            // Configuration write lands last so it overrides a same-cycle match.
            if (bus.cfg_wr) begin
                cmp_r[bus.cfg_ch]   <= bus.cfg_cmp;
                armed_r[bus.cfg_ch] <= bus.cfg_arm;
`ifdef TIMER_CMP_AUTO_RELOAD_EN
                per_r[bus.cfg_ch]    <= bus.cfg_per;
                reload_r[bus.cfg_ch] <= bus.cfg_reload;
                wrap_r[bus.cfg_ch]   <= 1'b0;
`endif
            end
        end
    end

    assign bus.int_sts   = sts_r;
    assign bus.cmp_match = match_r;
    assign bus.armed     = armed_r;
    assign bus.tim_int   = |(sts_r & bus.int_en);

endmodule
